// File: rtl/ecc_result_serializer_if.sv
// Bus between the ECC core and one result serializer.
// Core side (master) presents a parallel (x, y) result with a load strobe;
// serializer side (slave) returns ready/busy and the MSB-first serial stream.
//   i_load  : core presents a result this cycle
//   i_mode  : operand size 00=32, 01=64, 10=128, 11=256 bits
//   i_x/i_y : right-aligned result coordinates
//   o_ready : pending buffer empty, a load is accepted this cycle
//   o_valid : one-cycle start-of-frame strobe, coincident with the MSB
//   o_x/o_y : serial coordinate bits
//   o_busy  : shifter active or pending buffer full
interface ecc_result_serializer_if #(
   parameter int unsigned MAX_BITS = 256
);
   logic                i_load;
   logic [1:0]          i_mode;
   logic [MAX_BITS-1:0] i_x;
   logic [MAX_BITS-1:0] i_y;
   logic                o_ready;
   logic                o_valid;
   logic                o_x;
   logic                o_y;
   logic                o_busy;

   modport master (
      output i_load, i_mode, i_x, i_y,
      input  o_ready, o_valid, o_x, o_y, o_busy
   );

   modport slave (
      input  i_load, i_mode, i_x, i_y,
      output o_ready, o_valid, o_x, o_y, o_busy
   );
endinterface

// File: rtl/ecc_result_serializer.sv
// Transmit end of the ECC bit-serial result port. Takes a parallel point
// result and shifts it out MSB-first with a start-of-frame strobe, holding one
// further result in a pending buffer so frames can run back-to-back.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of ecc_result_serializer_if (load/mode/x/y in,
//         ready/valid/x/y/busy out)
module ecc_result_serializer #(
   parameter int unsigned MAX_BITS = 256
) (
   input logic                    clk,
   input logic                    rst,
   ecc_result_serializer_if.slave bus
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [MAX_BITS-1:0] sx_q, sx_d;
   logic [MAX_BITS-1:0] sy_q, sy_d;
   logic                pend_full_q, pend_full_d;
   logic [MAX_BITS-1:0] pend_x_q, pend_x_d;
   logic [MAX_BITS-1:0] pend_y_q, pend_y_d;
   logic [1:0]          pend_mode_q, pend_mode_d;
   logic                valid_q, valid_d;
   logic                ox_q, ox_d;
   logic                oy_q, oy_d;
   logic                busy_q, busy_d;

   logic                accept;
   logic                start;
   logic [MAX_BITS-1:0] src_x, src_y;
   logic [1:0]          src_mode;
   logic [MAX_BITS-1:0] aln_x, aln_y;

   // Left-align a frame so its MSB sits at the top of the shifter; bits at or
   // above the frame length fall off the top and are never sent.
   function automatic logic [MAX_BITS-1:0] align(input logic [MAX_BITS-1:0] op,
                                                 input logic [1:0]          mode);
      logic [MAX_BITS-1:0] r;
      case (mode)
         2'b00:   r = op << (MAX_BITS - 32);
         2'b01:   r = op << (MAX_BITS - 64);
         2'b10:   r = op << (MAX_BITS - 128);
         default: r = op << (MAX_BITS - 256);
      endcase
      return r;
   endfunction

   // Index of the MSB for a given mode (N-1).
   function automatic logic [CNT_W-1:0] last_idx(input logic [1:0] mode);
      logic [CNT_W-1:0] r;
      case (mode)
         2'b00:   r = CNT_W'(31);
         2'b01:   r = CNT_W'(63);
         2'b10:   r = CNT_W'(127);
         default: r = CNT_W'(255);
      endcase
      return r;
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         sx_q        <= '0;
         sy_q        <= '0;
         pend_full_q <= 1'b0;
         pend_x_q    <= '0;
         pend_y_q    <= '0;
         pend_mode_q <= 2'b00;
         valid_q     <= 1'b0;
         ox_q        <= 1'b0;
         oy_q        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         pend_full_q <= pend_full_d;
         pend_x_q    <= pend_x_d;
         pend_y_q    <= pend_y_d;
         pend_mode_q <= pend_mode_d;
         valid_q     <= valid_d;
         ox_q        <= ox_d;
         oy_q        <= oy_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and output logic. cnt_q is the index of the bit currently on
   // o_x/o_y; sx_q/sy_q hold the bits still to come, left-aligned.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sx_d        = sx_q;
      sy_d        = sy_q;
      pend_full_d = pend_full_q;
      pend_x_d    = pend_x_q;
      pend_y_d    = pend_y_q;
      pend_mode_d = pend_mode_q;
      valid_d     = 1'b0;
      ox_d        = 1'b0;
      oy_d        = 1'b0;
      accept      = bus.i_load && !pend_full_q;
      start       = 1'b0;
      src_x       = bus.i_x;
      src_y       = bus.i_y;
      src_mode    = bus.i_mode;
      aln_x       = '0;
      aln_y       = '0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               start = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != '0) begin
               ox_d  = sx_q[MAX_BITS-1];
               oy_d  = sy_q[MAX_BITS-1];
               sx_d  = sx_q << 1;
               sy_d  = sy_q << 1;
               cnt_d = cnt_q - CNT_W'(1);
               if (accept) begin
                  pend_full_d = 1'b1;
                  pend_x_d    = bus.i_x;
                  pend_y_d    = bus.i_y;
                  pend_mode_d = bus.i_mode;
               end
            end else if (pend_full_q) begin
               // Last bit on the wire: a buffered result wins over the input.
               start       = 1'b1;
               src_x       = pend_x_q;
               src_y       = pend_y_q;
               src_mode    = pend_mode_q;
               pend_full_d = 1'b0;
            end else if (accept) begin
               start = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Frame start: MSB goes straight to the output register with the strobe.
      if (start) begin
         aln_x   = align(src_x, src_mode);
         aln_y   = align(src_y, src_mode);
         ox_d    = aln_x[MAX_BITS-1];
         oy_d    = aln_y[MAX_BITS-1];
         sx_d    = aln_x << 1;
         sy_d    = aln_y << 1;
         cnt_d   = last_idx(src_mode);
         valid_d = 1'b1;
         state_d = ST_SHIFT;
      end

      busy_d = (state_d == ST_SHIFT) || pend_full_d;
   end

   assign bus.o_ready = !pend_full_q;
   assign bus.o_valid = valid_q;
   assign bus.o_x     = ox_q;
   assign bus.o_y     = oy_q;
   assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_ecc_result_serializer.sv
// Testbench for ecc_result_serializer: directed loads push expected frames
// into a scoreboard; a negedge monitor pops a frame on every o_valid and
// compares each serial bit, and checks the line is quiet between frames.
module tb_ecc_result_serializer;

   typedef struct {
      int unsigned  n;
      logic [255:0] x;
      logic [255:0] y;
   } frame_t;

   logic clk;
   logic rst;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   frame_t      sb[$];
   frame_t      cur;
   bit          in_frame = 1'b0;
   int unsigned bit_i    = 0;

   ecc_result_serializer_if #(.MAX_BITS(256)) bus ();

   ecc_result_serializer #(.MAX_BITS(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one load for a single edge; called #1 after a rising edge and
   // returns #1 after the edge that samples it.
   task automatic load(input logic [1:0] mode, input logic [255:0] x, input logic [255:0] y,
                       input bit exp_acc, input string name);
      bus.i_load = 1'b1;
      bus.i_mode = mode;
      bus.i_x    = x;
      bus.i_y    = y;
      chk({name, "_ready"}, 64'(bus.o_ready), 64'(exp_acc));
      if (exp_acc) sb.push_back('{32 << mode, x, y});
      @(posedge clk);
      #1;
      bus.i_load = 1'b0;
      bus.i_x    = '1;
      bus.i_y    = '1;
   endtask

   task automatic wait_cyc(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         in_frame = 1'b0;
      end else if (in_frame) begin
         bit_i = bit_i - 1;
         chk("mid_valid", 64'(bus.o_valid), 64'(0));
         chk("bit_x", 64'(bus.o_x), 64'(cur.x[bit_i]));
         chk("bit_y", 64'(bus.o_y), 64'(cur.y[bit_i]));
         if (bit_i == 0) in_frame = 1'b0;
      end else if (bus.o_valid) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_frame: got o_valid=1 expected no frame");
         end else begin
            cur   = sb.pop_front();
            bit_i = cur.n - 1;
            chk("msb_x", 64'(bus.o_x), 64'(cur.x[bit_i]));
            chk("msb_y", 64'(bus.o_y), 64'(cur.y[bit_i]));
            in_frame = (bit_i != 0);
         end
      end else begin
         chk("idle_xy", {62'h0, bus.o_x, bus.o_y}, 64'h0);
      end
   end

   initial begin
      logic [255:0] v2, x3, y3;
      rst        = 1'b1;
      bus.i_load = 1'b0;
      bus.i_mode = 2'b00;
      bus.i_x    = '0;
      bus.i_y    = '0;
      wait_cyc(3);
      chk("rst_valid", 64'(bus.o_valid), 64'(0));
      chk("rst_xy",    {62'h0, bus.o_x, bus.o_y}, 64'h0);
      chk("rst_busy",  64'(bus.o_busy), 64'(0));
      chk("rst_ready", 64'(bus.o_ready), 64'(1));
      rst = 1'b0;
      wait_cyc(1);

      // 1: 32-bit frame
      load(2'b00, 256'h8000_0001, 256'h7FFF_FFFE, 1'b1, "t1");
      chk("t1_valid", 64'(bus.o_valid), 64'(1));
      chk("t1_msb",   {62'h0, bus.o_x, bus.o_y}, 64'h2);
      chk("t1_busy",  64'(bus.o_busy), 64'(1));
      wait_cyc(32);
      chk("t1_idle_busy",  64'(bus.o_busy), 64'(0));
      chk("t1_idle_valid", 64'(bus.o_valid), 64'(0));

      // 2: 256-bit frame, then 64-bit frame with garbage above bit 63
      v2 = {1'b1, 254'h0, 1'b1};
      load(2'b11, v2, v2, 1'b1, "t2a");
      chk("t2a_msb", {62'h0, bus.o_x, bus.o_y}, 64'h3);
      wait_cyc(256);
      chk("t2a_done", 64'(bus.o_busy), 64'(0));
      x3 = {{6{32'hDEAD_BEEF}}, 64'h8000_0000_0000_0001};
      y3 = {{6{32'hFFFF_FFFF}}, 64'h0123_4567_89AB_CDEF};
      load(2'b01, x3, y3, 1'b1, "t2b");
      chk("t2b_msb", {62'h0, bus.o_x, bus.o_y}, 64'h2);
      wait_cyc(64);
      chk("t2b_done", 64'(bus.o_busy), 64'(0));

      // 3/4: A running, B into pending, C ignored, B follows A with no gap
      load(2'b00, 256'hA5A5_A5A5, 256'h0F0F_0F0F, 1'b1, "t3a");
      wait_cyc(4);
      load(2'b01, 256'hC000_0000_0000_0003, 256'h5555_5555_5555_5555, 1'b1, "t3b");
      chk("t3_ready_low", 64'(bus.o_ready), 64'(0));
      chk("t3_busy",      64'(bus.o_busy), 64'(1));
      load(2'b00, 256'hFFFF_FFFF, 256'hFFFF_FFFF, 1'b0, "t4c");
      wait_cyc(25);
      chk("t3_a_lsb_novalid", 64'(bus.o_valid), 64'(0));
      wait_cyc(1);
      chk("t3_b_valid", 64'(bus.o_valid), 64'(1));
      chk("t3_b_msb",   {62'h0, bus.o_x, bus.o_y}, 64'h2);
      chk("t3_b_ready", 64'(bus.o_ready), 64'(1));
      wait_cyc(64);
      chk("t4_idle_busy",  64'(bus.o_busy), 64'(0));
      chk("t4_idle_ready", 64'(bus.o_ready), 64'(1));

      // 5: load in the last-bit cycle with pending empty
      load(2'b00, 256'h0000_0001, 256'hFFFF_FFFF, 1'b1, "t5d");
      wait_cyc(31);
      load(2'b00, 256'h7FFF_FFFF, 256'h8000_0000, 1'b1, "t5e");
      chk("t5_e_valid", 64'(bus.o_valid), 64'(1));
      chk("t5_e_msb",   {62'h0, bus.o_x, bus.o_y}, 64'h1);
      chk("t5_e_ready", 64'(bus.o_ready), 64'(1));
      wait_cyc(32);
      chk("t5_done", 64'(bus.o_busy), 64'(0));

      // 6: async reset at bit 17 with a pending load
      load(2'b00, 256'hDEAD_BEEF, 256'h1234_5678, 1'b1, "t6f");
      wait_cyc(2);
      load(2'b00, 256'hCAFE_F00D, 256'h0BAD_CAFE, 1'b1, "t6g");
      repeat (11) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", 64'(bus.o_valid), 64'(0));
      chk("t6_rst_xy",    {62'h0, bus.o_x, bus.o_y}, 64'h0);
      chk("t6_rst_ready", 64'(bus.o_ready), 64'(1));
      chk("t6_rst_busy",  64'(bus.o_busy), 64'(0));
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(1);
      load(2'b01, 256'hF00D_0000_1234_5678, 256'h0000_FFFF_8765_4321, 1'b1, "t6h");
      chk("t6_h_valid", 64'(bus.o_valid), 64'(1));
      chk("t6_h_msb",   {62'h0, bus.o_x, bus.o_y}, 64'h2);
      wait_cyc(64);
      chk("t6_done",     64'(bus.o_busy), 64'(0));
      wait_cyc(2);
      chk("sb_empty",    64'(sb.size()), 64'(0));
      chk("no_open_frm", 64'(in_frame), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ecc_result_serializer.md
Name: ecc_result_serializer

Overview:
- Transmit end of the ECC core's bit-serial result interface: takes a parallel point result (x, y) from the point-multiplication datapath and drives the serial output port (valid + MSB-first x/y bit streams) that the host samples.
- One instance per result channel in the top-level wrapper: one for mP, one for mnP.
- Has a one-entry pending buffer, so the core can hand off the next result while the current one is still being shifted out.

Parameters:
- MAX_BITS, 256, width of the parallel operand registers; must be ≥ 256.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- i_load  input  1  core presents a result this cycle.
- i_mode  input  2  operand size for this result: 00=32, 01=64, 10=128, 11=256 bits.
- i_x  input  MAX_BITS  result x coordinate, right-aligned (bit 0 = LSB).
- i_y  input  MAX_BITS  result y coordinate, right-aligned.
- o_ready  output  1  pending buffer empty; a load is accepted this cycle.
- o_valid  output  1  one-cycle start-of-frame strobe, coincident with the MSB.
- o_x  output  1  serial x bit.
- o_y  output  1  serial y bit.
- o_busy  output  1  shifter active or pending buffer full.

Behaviour:
- Reset, asynchronous, any state:
  - o_valid=0, o_x=0, o_y=0, o_busy=0, o_ready=1.
  - Pending buffer cleared, FSM to IDLE, bit counter 0.
  - A frame in progress is aborted and never resumed.
- Accept rule: a load is accepted when i_load && o_ready at a rising edge. i_load while o_ready=0 is ignored; the result is dropped and the core must hold it.
- Frame length: N = 32 << mode, using the mode latched with that load. Bits N-1 down to 0 of i_x/i_y are sent; bits ≥ N are ignored.
- FSM state IDLE:
  - o_x=o_y=0, o_valid=0.
  - On an accepted load: operands and mode go directly to the shift registers, counter = N-1, state goes to SHIFT.
  - o_ready=1 throughout IDLE.
- FSM state SHIFT:
  - Each cycle drives o_x/o_y = bit[counter], then counter decrements.
  - First SHIFT cycle: o_valid=1 and o_x/o_y = bit N-1 (the MSB).
  - The remaining N-1 cycles have o_valid=0.
  - Latency: load accepted at edge k gives o_valid plus the MSB in the cycle after edge k, and the LSB N-1 cycles later.
- Pending buffer:
  - A load accepted while in SHIFT is written to the pending buffer; o_ready drops to 0 from the next cycle.
  - At the end of the last-bit cycle (counter = 0), the next frame source is, in priority order:
    - the pending buffer, if full (buffer freed, o_ready=1 next cycle);
    - else the input, if a load is accepted in that same cycle;
    - else go to IDLE.
  - Back-to-back frames have zero gap cycles; o_valid re-asserts on the next MSB.
- Simultaneous events:
  - Last-bit cycle with pending full: o_ready=0, so any input load is ignored.
  - Last-bit cycle with pending empty: the load goes straight to the shifter and is not written to the buffer.
- o_busy = (state==SHIFT) || pending full. It is registered so it matches the state visible in the same cycle.
- All outputs are registered. No combinational path from inputs to o_x, o_y or o_valid. o_ready depends only on the registered pending flag.
- The counter is 8 bits (0..255); it does not wrap because it is reloaded on every frame start.

Test Plan:
1. Reset, then load mode=00, x=0x80000001, y=0x7FFFFFFE → next cycle o_valid=1, o_x=1, o_y=0. Over 32 cycles o_x streams 1,0…0,1 and o_y streams 0,1…1,0. o_valid is high for exactly 1 cycle; IDLE afterwards with o_busy=0.
2. Mode=11, x=y=256'h1 with bit 255 also set → 256 serial bits; MSB and LSB equal 1, all others 0. Load mode=01 with garbage in bits 255:64 → only bits 63:0 are emitted.
3. Load A (mode=00) and, 5 cycles later, load B (mode=01) → B is held with o_ready=0. B's o_valid appears in the cycle right after A's LSB (zero gap), with B's 64 bits following.
4. Pending full, then i_load pulsed with C → C is ignored. After B completes, the block goes to IDLE and C never appears.
5. Load in A's last-bit cycle with pending empty → the new frame starts with zero gap. Check o_ready stays 1.
6. Assert rst asynchronously mid-frame (bit 17 of a 32-bit frame, plus a pending load) → outputs go to 0 immediately and o_ready=1. After release, a fresh load serializes correctly and the old data is never emitted.
